// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a small request
// sequencer. Each queued byte is popped into a holding register, announced
// with a one-clock tx_req pulse, and the sequencer then waits for tx_busy to
// rise and fall before it pops the next byte. If the transmitter never raises
// tx_busy, the same held byte is re-requested after BUSY_TO clocks.
module uart_tx_fifo #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int BUSY_TO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_ovf,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_req,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          idle
);

  // Timeout counter must be able to hold the value BUSY_TO itself.
  localparam int TW = (BUSY_TO < 1) ? 1 : $clog2(BUSY_TO + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(BUSY_TO);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAITB = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_s;
  logic          ovf_r;
  logic [7:0]    tx_data_r;
  logic          tx_req_r;
  state_t        state_r;
  state_t        state_s;
  logic [TW-1:0] tmo_r;
  logic [TW-1:0] tmo_s;
  logic          req_set_s;

  logic          full_s;
  logic          empty_s;
  logic          wr_ok_s;
  logic          ovf_set_s;
  logic          pop_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == {(AW+1){1'b0}});
  // A flush discards the same-cycle write silently and suppresses the pop,
  // so the pointers stay consistent when wptr is pulled back to rptr.
  assign wr_ok_s   = wr_en && !full_s && !flush;
  assign ovf_set_s = wr_en &&  full_s && !flush;
  assign pop_s     = (state_r == S_IDLE) && !empty_s && !flush;

  // Occupancy update: simultaneous write and pop leave the count unchanged.
  always_comb begin
    count_s = count_r;
    case ({wr_ok_s, pop_s})
      2'b10:   count_s = count_r + (AW+1)'(1'b1);
      2'b01:   count_s = count_r - (AW+1)'(1'b1);
      default: count_s = count_r;
    endcase
  end

  // Storage array write port; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, sticky overflow and the held transmit byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r    <= {AW{1'b0}};
      rptr_r    <= {AW{1'b0}};
      count_r   <= {(AW+1){1'b0}};
      ovf_r     <= 1'b0;
      tx_data_r <= 8'h00;
    end else begin
      if (flush) begin
        wptr_r  <= rptr_r;
        count_r <= {(AW+1){1'b0}};
      end else begin
        if (wr_ok_s) begin
          wptr_r <= wptr_r + AW'(1'b1);
        end
        count_r <= count_s;
      end
      if (pop_s) begin
        rptr_r    <= rptr_r + AW'(1'b1);
        tx_data_r <= mem_r[rptr_r];
      end
      // An overflowing write beats a same-cycle clear.
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Sequencer next-state, request and timeout-counter decode.
  always_comb begin
    state_s   = state_r;
    tmo_s     = tmo_r;
    req_set_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pop_s) begin
          req_set_s = 1'b1;
          state_s   = S_REQ;
        end else begin
          state_s   = S_IDLE;
        end
      end
      S_REQ: begin
        tmo_s   = {TW{1'b0}};
        state_s = S_WAITB;
      end
      S_WAITB: begin
        if (tx_busy) begin
          state_s = S_DONE;
        end else if (tmo_r == TMO_MAX) begin
          // Transmitter ignored the request: re-issue the same held byte.
          req_set_s = 1'b1;
          state_s   = S_REQ;
        end else begin
          tmo_s   = tmo_r + TW'(1'b1);
        end
      end
      S_DONE: begin
        if (!tx_busy) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        tmo_s   = {TW{1'b0}};
      end
    endcase
  end

  // Sequencer state, timeout counter and the one-clock request register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      tmo_r    <= {TW{1'b0}};
      tx_req_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      tmo_r    <= tmo_s;
      tx_req_r <= req_set_s;
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_req   = tx_req_r;
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;
  assign overflow = ovf_r;
  assign idle     = empty_s && (state_r == S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo. A small transmitter model can either
// answer requests automatically (busy for busy_len clocks) or be held at a
// fixed busy level by the stimulus. All checks happen on the falling edge.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       idle;

  // transmitter model controls
  logic       auto_mode = 1'b1;
  logic       man_busy  = 1'b0;
  int         busy_len  = 20;
  logic       auto_busy = 1'b0;
  int         busy_cnt  = 0;

  int         n_total = 0;
  int         n_pass  = 0;
  int         req_cnt = 0;
  int         max_cnt = 0;
  logic [7:0] rx[$];

  assign tx_busy = auto_mode ? auto_busy : man_busy;

  uart_tx_fifo #(.DEPTH(8), .AW(3), .BUSY_TO(15)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clr_ovf(clr_ovf), .tx_busy(tx_busy), .tx_data(tx_data), .tx_req(tx_req),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  // Auto transmitter: busy rises the edge after a request, lasts busy_len clocks.
  always @(posedge clk) begin
    if (!auto_mode) begin
      auto_busy <= 1'b0;
      busy_cnt  <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) auto_busy <= 1'b0;
    end else if (tx_req) begin
      auto_busy <= 1'b1;
      busy_cnt  <= busy_len;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: advance to the falling edge and update the observation records.
  task automatic step();
    @(negedge clk);
    if (tx_req) req_cnt++;
    if (tx_req && auto_mode) rx.push_back(tx_data);
    if (int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle_rx(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && !(idle && rx.size() == n); i++) step();
    check(tag, {31'd0, idle && rx.size() == n}, 32'd1);
  endtask

  initial begin
    int pt[3];
    int np;
    int req0;
    logic [7:0] exp_q[$];

    // ---------------- reset then idle ----------------
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_txdata", {24'd0, tx_data}, 32'h00);
    check("rst_noreq", req_cnt, 0);

    // ---------------- single byte ----------------
    wr(8'hA5);                                   // edge k
    check("sb_count1", {28'd0, count}, 32'd1);
    check("sb_req_k", {31'd0, tx_req}, 32'd0);
    step();                                      // edge k+1
    check("sb_req_k1", {31'd0, tx_req}, 32'd1);
    check("sb_data", {24'd0, tx_data}, 32'hA5);
    check("sb_count0", {28'd0, count}, 32'd0);
    check("sb_notidle", {31'd0, idle}, 32'd0);
    step();                                      // edge k+2
    check("sb_req_off", {31'd0, tx_req}, 32'd0);
    check("sb_busy_up", {31'd0, tx_busy}, 32'd1);
    for (int i = 0; i < 40 && tx_busy; i++) step();
    check("sb_busy_fell", {31'd0, tx_busy}, 32'd0);
    check("sb_done_idle0", {31'd0, idle}, 32'd0);
    step();
    check("sb_idle_back", {31'd0, idle}, 32'd1);
    check("sb_one_req", req_cnt, 1);
    check("sb_rx_n", rx.size(), 1);
    check("sb_rx0", {24'd0, rx[0]}, 32'hA5);

    // ---------------- fill / overflow ----------------
    auto_mode = 1'b0;
    man_busy  = 1'b1;
    for (int i = 1; i <= 9; i++) wr(8'(i));
    check("fo_count8", {28'd0, count}, 32'd8);
    check("fo_full", {31'd0, full}, 32'd1);
    check("fo_noovf_yet", {31'd0, overflow}, 32'd0);
    check("fo_inflight", {24'd0, tx_data}, 32'h01);
    wr(8'h0A);
    check("fo_ovf", {31'd0, overflow}, 32'd1);
    check("fo_count_cap", {28'd0, count}, 32'd8);
    clr_ovf = 1'b1;
    wr(8'h0B);
    clr_ovf = 1'b0;
    check("fo_set_wins", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("fo_clr", {31'd0, overflow}, 32'd0);
    rx.delete();
    auto_mode = 1'b1;
    wait_idle_rx(8, 1000, "fo_drain_wait");
    for (int i = 0; i < 8; i++) check("fo_order", {24'd0, rx[i]}, 32'(i + 2));
    check("fo_empty", {31'd0, empty}, 32'd1);

    // ---------------- timeout retry ----------------
    auto_mode = 1'b0;
    man_busy  = 1'b0;
    wr(8'h3C);
    wr_en = 1'b1;
    wr_data = 8'h4D;
    np = 0;
    for (int i = 0; i < 100 && np < 3; i++) begin
      step();
      wr_en = 1'b0;
      if (tx_req) begin
        pt[np] = i;
        check("to_data", {24'd0, tx_data}, 32'h3C);
        check("to_count", {28'd0, count}, 32'd1);
        np++;
      end
    end
    check("to_npulse", np, 3);
    check("to_first", pt[0], 0);
    check("to_gap1", pt[1] - pt[0], 17);
    check("to_gap2", pt[2] - pt[1], 17);
    man_busy = 1'b1;
    req0 = req_cnt;
    for (int i = 0; i < 40; i++) step();
    check("to_stopped", req_cnt - req0, 0);
    check("to_hold", {24'd0, tx_data}, 32'h3C);
    rx.delete();
    auto_mode = 1'b1;
    wait_idle_rx(1, 200, "to_drain_wait");
    check("to_next", {24'd0, rx[0]}, 32'h4D);

    // ---------------- wrap-around stream ----------------
    busy_len = 6;
    rx.delete();
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'(i * 37 + 11));
      for (int w = 0; w < 200 && full; w++) step();
      wr(8'(i * 37 + 11));
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
    wait_idle_rx(20, 2000, "wr_drain_wait");
    for (int i = 0; i < 20; i++) check("wr_order", {24'd0, rx[i]}, {24'd0, exp_q[i]});
    check("wr_maxcnt", max_cnt, 8);
    check("wr_noovf", {31'd0, overflow}, 32'd0);

    // ---------------- flush ----------------
    busy_len = 20;
    rx.delete();
    for (int i = 0; i < 6; i++) wr(8'(8'h61 + i));
    check("fl_count5", {28'd0, count}, 32'd5);
    flush = 1'b1;
    wr(8'hEE);
    flush = 1'b0;
    check("fl_count0", {28'd0, count}, 32'd0);
    check("fl_empty", {31'd0, empty}, 32'd1);
    check("fl_noovf", {31'd0, overflow}, 32'd0);
    check("fl_txdata", {24'd0, tx_data}, 32'h61);
    wait_idle_rx(1, 200, "fl_inflight_wait");
    check("fl_rx0", {24'd0, rx[0]}, 32'h61);
    for (int i = 0; i < 5; i++) step();
    check("fl_nomore", rx.size(), 1);

    // ---------------- async reset mid S_WAITB ----------------
    auto_mode = 1'b0;
    man_busy  = 1'b0;
    wr(8'h77); wr(8'h78); wr(8'h79);
    step(); step(); step();
    check("ar_pre_count", {28'd0, count}, 32'd2);
    check("ar_pre_data", {24'd0, tx_data}, 32'h77);
    #2 rst = 1'b1;
    #1;
    check("ar_txdata", {24'd0, tx_data}, 32'h00);
    check("ar_txreq", {31'd0, tx_req}, 32'd0);
    check("ar_count", {28'd0, count}, 32'd0);
    check("ar_empty", {31'd0, empty}, 32'd1);
    check("ar_idle", {31'd0, idle}, 32'd1);
    step();
    rst = 1'b0;
    req0 = req_cnt;
    step(); step();
    check("ar_quiet", req_cnt - req0, 0);
    check("ar_idle_after", {31'd0, idle}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
